// File: rtl/id_fwd_stage_pkg.sv
// Shared decode constants, decode record and the instruction decoder for id_fwd_stage.
// Shift decode (SLL/SRL/SRA) is compiled in only when ID_SHIFT_EN is defined.
package id_fwd_stage_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    localparam logic [7:0] ALUOP_NOP = 8'h00;
    localparam logic [7:0] ALUOP_AND = 8'h24;
    localparam logic [7:0] ALUOP_OR  = 8'h25;
    localparam logic [7:0] ALUOP_XOR = 8'h26;
    localparam logic [7:0] ALUOP_NOR = 8'h27;
    localparam logic [7:0] ALUOP_SLL = 8'h7C;
    localparam logic [7:0] ALUOP_SRL = 8'h02;
    localparam logic [7:0] ALUOP_SRA = 8'h03;

    typedef enum logic [2:0] {
        ALUSEL_NOP   = 3'd0,
        ALUSEL_LOGIC = 3'd1,
        ALUSEL_SHIFT = 3'd2
    } alusel_e;

    // Which value feeds a read port whose enable is clear.
    typedef enum logic [1:0] {
        IMM_NONE   = 2'd0,
        IMM_ZEXT16 = 2'd1,
        IMM_LUI    = 2'd2,
        IMM_SA     = 2'd3
    } imm_kind_e;

    typedef struct packed {
        logic      inst_valid;
        logic [7:0] aluop;
        alusel_e   alusel;
        logic      re1;
        logic      re2;
        logic      wreg;
        logic      wd_is_rd;
        imm_kind_e imm_kind;
    } dec_t;

    function automatic dec_t id_decode(input logic [31:0] inst);
        dec_t d;
        d = '0;
        if (inst == 32'h0) begin
            d.inst_valid = 1'b1;
        end else begin
            case (inst[31:26])
                OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
                    d.inst_valid = 1'b1;
                    d.alusel     = ALUSEL_LOGIC;
                    d.re1        = 1'b1;
                    d.wreg       = 1'b1;
                    d.imm_kind   = (inst[31:26] == OP_LUI) ? IMM_LUI : IMM_ZEXT16;
                    d.aluop      = (inst[31:26] == OP_ANDI) ? ALUOP_AND :
                                   (inst[31:26] == OP_XORI) ? ALUOP_XOR : ALUOP_OR;
                end
                OP_SPECIAL: begin
                    case (inst[5:0])
                        FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                            d.inst_valid = 1'b1;
                            d.alusel     = ALUSEL_LOGIC;
                            d.re1        = 1'b1;
                            d.re2        = 1'b1;
                            d.wreg       = 1'b1;
                            d.wd_is_rd   = 1'b1;
                            d.aluop      = (inst[5:0] == FN_AND) ? ALUOP_AND :
                                           (inst[5:0] == FN_OR)  ? ALUOP_OR  :
                                           (inst[5:0] == FN_XOR) ? ALUOP_XOR : ALUOP_NOR;
                        end
`ifdef ID_SHIFT_EN
                        FN_SLL, FN_SRL, FN_SRA: begin
                            d.inst_valid = 1'b1;
                            d.alusel     = ALUSEL_SHIFT;
                            d.re2        = 1'b1;
                            d.wreg       = 1'b1;
                            d.wd_is_rd   = 1'b1;
                            d.imm_kind   = IMM_SA;
                            d.aluop      = (inst[5:0] == FN_SLL) ? ALUOP_SLL :
                                           (inst[5:0] == FN_SRL) ? ALUOP_SRL : ALUOP_SRA;
                        end
`endif
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand resolver for one regfile read port: $0, forwarding sources (lowest index wins),
// then regfile; also flags a load-use stall when the winning source is still pending.
module id_fwd_mux #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                        i_re,
    input  logic [REG_AW-1:0]           i_addr,
    input  logic [DATA_W-1:0]           i_rf_data,
    input  logic [DATA_W-1:0]           i_imm,
    input  logic [NUM_FWD-1:0]          i_fwd_we,
    input  logic [NUM_FWD-1:0]          i_fwd_pend,
    input  logic [NUM_FWD*REG_AW-1:0]   i_fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0]   i_fwd_data,
    output logic [DATA_W-1:0]           o_data,
    output logic                        o_stall
);

    logic              w_hit;
    logic              w_pend;
    logic [DATA_W-1:0] w_fwd;

    // Walk from the oldest source down so the newest match overwrites.
    always_comb begin
        w_hit  = 1'b0;
        w_pend = 1'b0;
        w_fwd  = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (i_fwd_we[i] && (i_fwd_addr[i*REG_AW +: REG_AW] == i_addr)) begin
                w_hit  = 1'b1;
                w_pend = i_fwd_pend[i];
                w_fwd  = i_fwd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign o_data  = !i_re             ? i_imm :
                     (i_addr == '0)    ? '0    :
                     w_hit             ? w_fwd : i_rf_data;
    assign o_stall = i_re && (i_addr != '0) && w_hit && w_pend;

endmodule

// File: rtl/id_fwd_stage.sv
// OpenMIPS ID stage: decode, operand forwarding, load-use stall and an ID/EX output register.
// Define ID_SHIFT_EN to decode SLL/SRL/SRA; otherwise those encodings are unrecognised.
module id_fwd_stage
    import id_fwd_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 pc_i,
    input  logic [31:0]                 inst_i,
    input  logic                        flush_i,
    output logic                        reg1_read_o,
    output logic                        reg2_read_o,
    output logic [REG_AW-1:0]           reg1_addr_o,
    output logic [REG_AW-1:0]           reg2_addr_o,
    input  logic [DATA_W-1:0]           reg1_data_i,
    input  logic [DATA_W-1:0]           reg2_data_i,
    input  logic [NUM_FWD-1:0]          fwd_we_i,
    input  logic [NUM_FWD-1:0]          fwd_pend_i,
    input  logic [NUM_FWD*REG_AW-1:0]   fwd_addr_i,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_data_i,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 pc_o,
    output logic [7:0]                  aluop_o,
    output logic [2:0]                  alusel_o,
    output logic [DATA_W-1:0]           reg1_o,
    output logic [DATA_W-1:0]           reg2_o,
    output logic [REG_AW-1:0]           wd_o,
    output logic                        wreg_o,
    output logic                        instvalid_o,
    output logic [15:0]                 stall_cnt_o
);

    dec_t              w_dec;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_wd;
    logic              w_stall1;
    logic              w_stall2;
    logic              w_stall;
    logic              w_take;

    logic              r_valid;
    logic [31:0]       r_pc;
    logic [7:0]        r_aluop;
    logic [2:0]        r_alusel;
    logic [DATA_W-1:0] r_reg1;
    logic [DATA_W-1:0] r_reg2;
    logic [REG_AW-1:0] r_wd;
    logic              r_wreg;
    logic              r_instvalid;
    logic [15:0]       r_stall_cnt;

    assign w_dec = id_decode(inst_i);
    assign w_rs  = REG_AW'(inst_i[25:21]);
    assign w_rt  = REG_AW'(inst_i[20:16]);
    assign w_wd  = !w_dec.wreg   ? '0 :
                   w_dec.wd_is_rd ? REG_AW'(inst_i[15:11]) : w_rt;

    always_comb begin
        w_imm = '0;
        case (w_dec.imm_kind)
            IMM_ZEXT16: w_imm = DATA_W'(inst_i[15:0]);
            IMM_LUI:    w_imm = DATA_W'({inst_i[15:0], 16'h0000});
            IMM_SA:     w_imm = DATA_W'(inst_i[10:6]);
            default:    w_imm = '0;
        endcase
    end

    assign reg1_read_o = !rst && w_dec.re1;
    assign reg2_read_o = !rst && w_dec.re2;
    assign reg1_addr_o = rst ? '0 : w_rs;
    assign reg2_addr_o = rst ? '0 : w_rt;

    id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux1 (
        .i_re(reg1_read_o), .i_addr(w_rs), .i_rf_data(reg1_data_i), .i_imm(w_imm),
        .i_fwd_we(fwd_we_i), .i_fwd_pend(fwd_pend_i), .i_fwd_addr(fwd_addr_i),
        .i_fwd_data(fwd_data_i), .o_data(w_op1), .o_stall(w_stall1)
    );

    id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux2 (
        .i_re(reg2_read_o), .i_addr(w_rt), .i_rf_data(reg2_data_i), .i_imm(w_imm),
        .i_fwd_we(fwd_we_i), .i_fwd_pend(fwd_pend_i), .i_fwd_addr(fwd_addr_i),
        .i_fwd_data(fwd_data_i), .o_data(w_op2), .o_stall(w_stall2)
    );

    // Handshake: a transfer happens on an edge where valid && ready; flush overrides and
    // accepts-and-drops; a stall only exists while an instruction is actually presented.
    assign w_stall  = in_valid && !flush_i && (w_stall1 || w_stall2);
    assign in_ready = flush_i || (!w_stall && (!r_valid || out_ready));
    assign w_take   = in_valid && in_ready && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_aluop     <= '0;
            r_alusel    <= '0;
            r_reg1      <= '0;
            r_reg2      <= '0;
            r_wd        <= '0;
            r_wreg      <= 1'b0;
            r_instvalid <= 1'b1;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_take) begin
            r_valid     <= 1'b1;
            r_pc        <= pc_i;
            r_aluop     <= w_dec.aluop;
            r_alusel    <= w_dec.alusel;
            r_reg1      <= w_op1;
            r_reg2      <= w_op2;
            r_wd        <= w_wd;
            r_wreg      <= w_dec.wreg;
            r_instvalid <= w_dec.inst_valid;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign out_valid   = r_valid;
    assign pc_o        = r_pc;
    assign aluop_o     = r_aluop;
    assign alusel_o    = r_alusel;
    assign reg1_o      = r_reg1;
    assign reg2_o      = r_reg2;
    assign wd_o        = r_wd;
    assign wreg_o      = r_wreg;
    assign instvalid_o = r_instvalid;
    assign stall_cnt_o = r_stall_cnt;

endmodule
